// File: rtl/mips_bus_port.sv
// Avalon-MM master front end: arbitrates fetch and load/store channels onto one bus,
// with store lane steering and load extraction. Optional misalignment trap: MIPS_BUS_MISALIGN_TRAP_EN.
module mips_bus_port #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned ARB_MODE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [31:0]       f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_signed,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [31:0]       writedata,
    output logic [3:0]        byteenable,
    input  logic              waitrequest,
    input  logic [31:0]       readdata,
    output logic              active
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

`ifdef MIPS_BUS_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [1:0]        state, state_n;
    logic [ADDR_W-1:0] address_n;
    logic              read_n, write_n, f_ack_n, d_ack_n, d_err_n, active_n;
    logic [31:0]       writedata_n, f_rdata_n, d_rdata_n;
    logic [3:0]        byteenable_n;
    logic              gnt_d, gnt_d_n, last_d, last_d_n;
    logic [1:0]        lane_a, lane_a_n, lane_size, lane_size_n;
    logic              lane_sgn, lane_sgn_n, lane_we, lane_we_n;

    logic              d_is_byte, d_is_half, d_mis, pick_d;
    logic [3:0]        d_be;
    logic [31:0]       d_wd, ld_val;
    logic [7:0]        sh_b;
    logic [15:0]       sh_h;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^f_addr[1:0];

    // Request decode: lane enables, replicated store data, misalignment, grant choice
    always_comb begin
        d_is_byte = (d_size == 2'd0);
        d_is_half = (d_size == 2'd1);
        d_mis     = (d_is_half && d_addr[0]) || (!d_is_byte && !d_is_half && (d_addr[1:0] != 2'b00));
        if (d_is_byte) begin
            d_be = 4'b0001 << d_addr[1:0];
            d_wd = {4{d_wdata[7:0]}};
        end else if (d_is_half) begin
            d_be = d_addr[1] ? 4'b1100 : 4'b0011;
            d_wd = {2{d_wdata[15:0]}};
        end else begin
            d_be = 4'b1111;
            d_wd = d_wdata;
        end
        // last-granted channel loses a tie in round-robin mode
        pick_d = d_req && (!f_req || (ARB_MODE == 0) || !last_d);
    end

    // Load lane extraction and extension from the captured lane info
    always_comb begin
        sh_b = 8'(readdata >> {lane_a, 3'b000});
        sh_h = 16'(readdata >> {lane_a[1], 4'b0000});
        case (lane_size)
            2'd0:    ld_val = {{24{lane_sgn & sh_b[7]}}, sh_b};
            2'd1:    ld_val = {{16{lane_sgn & sh_h[15]}}, sh_h};
            default: ld_val = readdata;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_n      = state;
        address_n    = address;
        read_n       = read;
        write_n      = write;
        writedata_n  = writedata;
        byteenable_n = byteenable;
        f_ack_n      = 1'b0;
        f_rdata_n    = f_rdata;
        d_ack_n      = 1'b0;
        d_rdata_n    = d_rdata;
        d_err_n      = 1'b0;
        gnt_d_n      = gnt_d;
        last_d_n     = last_d;
        lane_a_n     = lane_a;
        lane_size_n  = lane_size;
        lane_sgn_n   = lane_sgn;
        lane_we_n    = lane_we;
        case (state)
            S_IDLE: begin
                if (f_req || d_req) begin
                    gnt_d_n  = pick_d;
                    last_d_n = pick_d;
                    if (pick_d) begin
                        lane_a_n    = d_addr[1:0];
                        lane_size_n = d_size;
                        lane_sgn_n  = d_signed;
                        lane_we_n   = d_we;
                        if (TRAP_EN && d_mis) begin
                            d_ack_n   = 1'b1;
                            d_err_n   = 1'b1;
                            d_rdata_n = 32'd0;
                            state_n   = S_DONE;
                        end else begin
                            address_n    = {d_addr[ADDR_W-1:2], 2'b00};
                            byteenable_n = d_be;
                            writedata_n  = d_wd;
                            read_n       = !d_we;
                            write_n      = d_we;
                            state_n      = S_BUS;
                        end
                    end else begin
                        address_n    = {f_addr[ADDR_W-1:2], 2'b00};
                        byteenable_n = 4'b1111;
                        writedata_n  = 32'd0;
                        read_n       = 1'b1;
                        write_n      = 1'b0;
                        state_n      = S_BUS;
                    end
                end
            end
            S_BUS: begin
                if (!waitrequest) begin
                    read_n  = 1'b0;
                    write_n = 1'b0;
                    state_n = S_DONE;
                    if (gnt_d) begin
                        d_ack_n   = 1'b1;
                        d_rdata_n = lane_we ? 32'd0 : ld_val;
                    end else begin
                        f_ack_n   = 1'b1;
                        f_rdata_n = readdata;
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        active_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            address    <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            writedata  <= 32'd0;
            byteenable <= 4'b0000;
            f_ack      <= 1'b0;
            f_rdata    <= 32'd0;
            d_ack      <= 1'b0;
            d_rdata    <= 32'd0;
            d_err      <= 1'b0;
            active     <= 1'b0;
            gnt_d      <= 1'b0;
            last_d     <= 1'b0;
            lane_a     <= 2'd0;
            lane_size  <= 2'd0;
            lane_sgn   <= 1'b0;
            lane_we    <= 1'b0;
        end else begin
            state      <= state_n;
            address    <= address_n;
            read       <= read_n;
            write      <= write_n;
            writedata  <= writedata_n;
            byteenable <= byteenable_n;
            f_ack      <= f_ack_n;
            f_rdata    <= f_rdata_n;
            d_ack      <= d_ack_n;
            d_rdata    <= d_rdata_n;
            d_err      <= d_err_n;
            active     <= active_n;
            gnt_d      <= gnt_d_n;
            last_d     <= last_d_n;
            lane_a     <= lane_a_n;
            lane_size  <= lane_size_n;
            lane_sgn   <= lane_sgn_n;
            lane_we    <= lane_we_n;
        end
    end

endmodule

// File: doc/mips_bus_port.md
# mips_bus_port

Parametrised Avalon-MM master front end for the multicycle MIPS core. It arbitrates an instruction-fetch channel and a load/store data channel onto one Avalon bus and holds each transfer through `waitrequest`. Byte-lane steering for stores and lane extraction with sign/zero extension for loads are done here, so the core datapath only ever sees right-justified 32-bit values. It replaces the core's ad-hoc address/byteenable/mem-decode glue.

## Interface

Parameters:
- `ADDR_W`, default 32: width of byte addresses on the client channels and the bus.
- `ARB_MODE`, default 0: 0 = fixed priority, data channel wins; 1 = round-robin between channels.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `f_req` in 1: fetch request; held high with `f_addr` stable until `f_ack`.
- `f_addr` in ADDR_W: fetch byte address; bits [1:0] are ignored.
- `f_ack` out 1: one-cycle fetch completion pulse.
- `f_rdata` out 32: fetched word; valid while `f_ack`=1.
- `d_req` in 1: data request; held with all `d_*` inputs stable until `d_ack`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_size` in 2: 0 = byte, 1 = half, 2 = word (3 is treated as word).
- `d_signed` in 1: 1 = sign-extend loaded byte/half, 0 = zero-extend.
- `d_addr` in ADDR_W: data byte address.
- `d_wdata` in 32: store data, right-justified.
- `d_ack` out 1: one-cycle data completion pulse.
- `d_rdata` out 32: extended load result; valid while `d_ack`=1, 0 for stores.
- `d_err` out 1: misalignment error, valid while `d_ack`=1.
- `address` out ADDR_W: Avalon word address, always a byte address with [1:0]=0.
- `read` out 1, `write` out 1: Avalon strobes, never both high.
- `writedata` out 32, `byteenable` out 4: Avalon write data and lane enables.
- `waitrequest` in 1, `readdata` in 32: Avalon slave response; `readdata` is valid in the cycle where `read`=1 and `waitrequest`=0.
- `active` out 1: high whenever the state is not IDLE.

## Operation

- States: IDLE, BUS, DONE.
- IDLE: sample `f_req`/`d_req`. With none high, stay in IDLE. With one or both high, grant a channel per `ARB_MODE`. Register `address`, `byteenable`, `writedata`, and `read`/`write`, then go to BUS. A granted misaligned data request with the trap compiled in goes directly to DONE with error.
- Round-robin: the last-granted channel loses the next tie. After reset the data channel wins the first tie.
- BUS: hold all bus outputs unchanged while `waitrequest`=1. On `waitrequest`=0:
  - capture `readdata`, extracting and extending it for data loads;
  - drop `read`/`write`;
  - go to DONE.
- DONE: pulse the granted channel's ack for exactly one cycle, then go to IDLE. The other channel's request stays pending and is arbitrated in IDLE.
- Lane rules, with a = `d_addr[1:0]`:
  - byte: `byteenable` = 1<<a; writedata = {4{wdata[7:0]}}; rdata = readdata >> (8·a), extended from bit 7.
  - half: `byteenable` = a[1] ? 1100 : 0011; writedata = {2{wdata[15:0]}}; rdata = readdata >> (16·a[1]), extended from bit 15.
  - word: `byteenable` = 1111; writedata = wdata; rdata = readdata.
  - fetch: always word, `byteenable` = 1111.
- Misaligned means a half with a[0]=1, or a word with a≠0.
- Reset asserted mid-transfer: every output goes to its reset value immediately, and the transfer is abandoned with no ack.

## Timing

- Reset values:
  - `read`, `write`, `f_ack`, `d_ack`, `d_err`, `active` = 0;
  - `address`, `writedata`, `f_rdata`, `d_rdata` = 0;
  - `byteenable` = 0000;
  - state = IDLE.
- The request is sampled at edge N. Bus strobes are high from cycle N+1.
- With zero wait states (`waitrequest`=0 in N+1), the ack is in N+2. Each wait cycle adds one cycle.
- Minimum spacing between two transfers is 3 cycles. A new request is not sampled before the IDLE cycle that follows DONE.
- A misaligned trap gives an ack at N+1 with no bus cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

- `MIPS_BUS_MISALIGN_TRAP_EN` defined:
  - a misaligned data request issues no bus cycle;
  - it gets `d_ack`=1 with `d_err`=1 and `d_rdata`=0 one cycle after the grant;
  - no Avalon strobe is raised.
- Undefined:
  - `d_err` is tied to 0;
  - misaligned requests proceed with the offending low bits ignored: half uses a[1] only, word ignores a[1:0].

## Test plan

- Zero-wait fetch: `f_addr`=0x00000104 → `read`=1, `address`=0x104, `byteenable`=1111; `readdata`=0x8C820004 → `f_ack` two cycles after the request with `f_rdata`=0x8C820004.
- Wait states on store byte: SB with `d_addr`=0x203 and `d_wdata`=0x000000A5, 3 cycles of `waitrequest`=1 → strobe and fields held stable throughout; `byteenable`=1000, `writedata`=0xA5A5A5A5; `d_ack` 5 cycles after the request.
- Load extension: `readdata`=0x80FF7F01 gives:
  - LB a=2, signed → 0xFFFFFFFF;
  - LBU a=3 → 0x00000080;
  - LH a=2, signed → 0xFFFF80FF;
  - LHU a=0 → 0x00007F01.
- Arbitration: `f_req` and `d_req` high together, repeated with both requests reasserted after each ack.
  - `ARB_MODE`=0 → data, data, data.
  - `ARB_MODE`=1 → grants alternate data, fetch, data.
- Misaligned LW at 0x102:
  - trap defined → `d_err`=1, no `read` pulse;
  - trap undefined → `address`=0x100, `d_err`=0.
- Reset during BUS with `waitrequest`=1 → `read` low asynchronously, no ack; the first request after release completes normally.
